// File: rtl/qpi_target_core_pkg.sv
// Shared definitions for the QPI memory target: FSM state encoding, default
// opcodes and per-phase nibble counts.
package qpi_target_core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } qpi_state_t;

   localparam logic [7:0] CMD_READ_DEF  = 8'hEB;
   localparam logic [7:0] CMD_WRITE_DEF = 8'h38;

   // Index of the final nibble in the opcode and address phases.
   localparam logic [2:0] CMD_LAST  = 3'd1;
   localparam logic [2:0] ADDR_LAST = 3'd5;

endpackage

// File: rtl/qpi_target_core_sync.sv
// Brings pad-level qpi_clk, qpi_cs_n and qpi_io_i into the system clock domain
// and flags the edges of qpi_clk and the falling edge of qpi_cs_n.
module qpi_target_core_sync
   import qpi_target_core_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       qpi_clk,
   input  logic       qpi_cs_n,
   input  logic [3:0] qpi_io_i,
   output logic       sclk_rise,
   output logic       sclk_fall,
   output logic       cs_n_sync,
   output logic       cs_n_fall,
   output logic [3:0] io_sync
);

   logic [SYNC_STAGES-1:0] clk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [3:0]             io_sr [SYNC_STAGES];
   logic                   clk_d;
   logic                   cs_d;

   // chip select resets high so the core never sees a spurious select at startup
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sr <= '0;
         cs_sr  <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) io_sr[i] <= 4'h0;
         clk_d  <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         clk_sr <= {clk_sr[SYNC_STAGES-2:0], qpi_clk};
         cs_sr  <= {cs_sr[SYNC_STAGES-2:0], qpi_cs_n};
         io_sr[0] <= qpi_io_i;
         for (int i = 1; i < SYNC_STAGES; i++) io_sr[i] <= io_sr[i-1];
         clk_d  <= clk_sr[SYNC_STAGES-1];
         cs_d   <= cs_sr[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = clk_sr[SYNC_STAGES-1] & ~clk_d;
   assign sclk_fall = ~clk_sr[SYNC_STAGES-1] & clk_d;
   assign cs_n_sync = cs_sr[SYNC_STAGES-1];
   assign cs_n_fall = ~cs_sr[SYNC_STAGES-1] & cs_d;
   assign io_sync   = io_sr[SYNC_STAGES-1];

endmodule

// File: rtl/qpi_target_core.sv
// QPI memory target: decodes quad read/write commands from an oversampled QPI
// link and drives a byte-wide synchronous memory, returning read data on io.
module qpi_target_core
   import qpi_target_core_pkg::*;
#(
   parameter int         SYNC_STAGES  = 2,
   parameter int         DUMMY_CYCLES = 6,
   parameter logic [7:0] CMD_READ     = CMD_READ_DEF,
   parameter logic [7:0] CMD_WRITE    = CMD_WRITE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        qpi_clk,
   input  logic        qpi_cs_n,
   input  logic [3:0]  qpi_io_i,
   output logic [3:0]  qpi_io_o,
   output logic [3:0]  qpi_io_oe,
   output logic [23:0] mi_addr,
   output logic [7:0]  mi_wdata,
   output logic        mi_we,
   output logic        mi_re,
   input  logic [7:0]  mi_rdata
);

   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

   logic        sclk_rise;
   logic        sclk_fall;
   logic        cs_n_sync;
   logic        cs_n_fall;
   logic [3:0]  io_sync;

   qpi_state_t  state;
   qpi_state_t  next_state;
   logic [2:0]  nib_cnt;
   logic [7:0]  dummy_cnt;
   logic [3:0]  cmd_hi;
   logic [7:0]  cmd_byte;
   logic        is_read;
   logic [19:0] addr_sr;
   logic [23:0] addr_full;
   logic [23:0] addr_reg;
   logic [3:0]  wr_hi;
   logic [7:0]  prefetch;
   logic [3:0]  low_hold;
   logic        load_hi;
   logic        rd_valid;

   qpi_target_core_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .qpi_clk   (qpi_clk),
      .qpi_cs_n  (qpi_cs_n),
      .qpi_io_i  (qpi_io_i),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_n_sync (cs_n_sync),
      .cs_n_fall (cs_n_fall),
      .io_sync   (io_sync)
   );

   assign cmd_byte  = {cmd_hi, io_sync};
   assign addr_full = {addr_sr, io_sync};

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // deselect wins over every phase transition
   always_comb begin
      next_state = state;
      if (cs_n_sync) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:
               if (cs_n_fall) next_state = ST_CMD;
            ST_CMD:
               if (sclk_rise && nib_cnt == CMD_LAST)
                  next_state = (cmd_byte == CMD_READ || cmd_byte == CMD_WRITE) ? ST_ADDR : ST_IGNORE;
            ST_ADDR:
               if (sclk_rise && nib_cnt == ADDR_LAST)
                  next_state = is_read ? ST_DUMMY : ST_WDATA;
            ST_DUMMY:
               if (sclk_rise && dummy_cnt == DUMMY_LAST) next_state = ST_RDATA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         qpi_io_o  <= 4'h0;
         qpi_io_oe <= 4'h0;
         mi_addr   <= 24'h0;
         mi_wdata  <= 8'h0;
         mi_we     <= 1'b0;
         mi_re     <= 1'b0;
         nib_cnt   <= 3'd0;
         dummy_cnt <= 8'd0;
         cmd_hi    <= 4'h0;
         is_read   <= 1'b0;
         addr_sr   <= 20'h0;
         addr_reg  <= 24'h0;
         wr_hi     <= 4'h0;
         prefetch  <= 8'h0;
         low_hold  <= 4'h0;
         load_hi   <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         mi_we    <= 1'b0;
         mi_re    <= 1'b0;
         rd_valid <= mi_re;
         if (rd_valid) prefetch <= mi_rdata;

         if (cs_n_sync) begin
            qpi_io_oe <= 4'h0;
            nib_cnt   <= 3'd0;
            dummy_cnt <= 8'd0;
            load_hi   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE:
                  if (cs_n_fall) begin
                     nib_cnt   <= 3'd0;
                     dummy_cnt <= 8'd0;
                  end
               ST_CMD:
                  if (sclk_rise) begin
                     cmd_hi  <= io_sync;
                     nib_cnt <= nib_cnt + 3'd1;
                     if (nib_cnt == CMD_LAST) begin
                        is_read <= (cmd_byte == CMD_READ);
                        nib_cnt <= 3'd0;
                     end
                  end
               // the first read byte is fetched as soon as the address is complete
               ST_ADDR:
                  if (sclk_rise) begin
                     addr_sr <= addr_full[19:0];
                     nib_cnt <= nib_cnt + 3'd1;
                     if (nib_cnt == ADDR_LAST) begin
                        nib_cnt  <= 3'd0;
                        addr_reg <= addr_full;
                        if (is_read) begin
                           mi_re   <= 1'b1;
                           mi_addr <= addr_full;
                        end
                     end
                  end
               ST_DUMMY:
                  if (sclk_rise) begin
                     dummy_cnt <= dummy_cnt + 8'd1;
                     if (dummy_cnt == DUMMY_LAST) load_hi <= 1'b1;
                  end
               // the low nibble is parked so the prefetch can be refilled for the next byte
               ST_RDATA:
                  if (sclk_fall) begin
                     if (load_hi) begin
                        qpi_io_oe <= 4'hF;
                        qpi_io_o  <= prefetch[7:4];
                        low_hold  <= prefetch[3:0];
                        load_hi   <= 1'b0;
                        addr_reg  <= addr_reg + 24'd1;
                        mi_addr   <= addr_reg + 24'd1;
                        mi_re     <= 1'b1;
                     end else begin
                        qpi_io_o  <= low_hold;
                        load_hi   <= 1'b1;
                     end
                  end
               ST_WDATA:
                  if (sclk_rise) begin
                     if (!nib_cnt[0]) begin
                        wr_hi   <= io_sync;
                        nib_cnt <= 3'd1;
                     end else begin
                        mi_wdata <= {wr_hi, io_sync};
                        mi_addr  <= addr_reg;
                        mi_we    <= 1'b1;
                        addr_reg <= addr_reg + 24'd1;
                        nib_cnt  <= 3'd0;
                     end
                  end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qpi_target_core.sv
// Self-checking bench for qpi_target_core: a QPI controller model drives the pads,
// a small memory model answers strobes, and writes/read nibbles go through scoreboards.
module tb_qpi_target_core;

   localparam int HALF  = 8;
   localparam int DUMMY = 6;

   typedef struct {
      logic [23:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        qpi_clk;
   logic        qpi_cs_n;
   logic [3:0]  qpi_io_i;
   logic [3:0]  qpi_io_o;
   logic [3:0]  qpi_io_oe;
   logic [23:0] mi_addr;
   logic [7:0]  mi_wdata;
   logic        mi_we;
   logic        mi_re;
   logic [7:0]  mi_rdata;

   logic [7:0]  mem [256];
   wr_t         wr_q [$];
   logic [3:0]  nib_q [$];
   int          total;
   int          bad;
   logic        quiet_watch;
   int          quiet_hits;

   qpi_target_core dut (
      .clk       (clk),
      .rst       (rst),
      .qpi_clk   (qpi_clk),
      .qpi_cs_n  (qpi_cs_n),
      .qpi_io_i  (qpi_io_i),
      .qpi_io_o  (qpi_io_o),
      .qpi_io_oe (qpi_io_oe),
      .mi_addr   (mi_addr),
      .mi_wdata  (mi_wdata),
      .mi_we     (mi_we),
      .mi_re     (mi_re),
      .mi_rdata  (mi_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: registered read data one clock after the strobe
   always @(posedge clk) begin
      if (rst) begin
         mem[8'h10] <= 8'hA5;
         mem[8'h11] <= 8'h3C;
         mi_rdata   <= 8'h00;
      end else begin
         if (mi_re) mi_rdata <= mem[mi_addr[7:0]];
         if (mi_we) mem[mi_addr[7:0]] <= mi_wdata;
      end
   end

   // write scoreboard and strobe-exclusivity monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (mi_we && mi_re) begin
            total++;
            bad++;
            $display("[TB] FAIL strobe_overlap: mi_we=%0b mi_re=%0b required not both", mi_we, mi_re);
         end
         if (mi_we) begin
            total++;
            if (wr_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_write: addr=%06h data=%02h required no write", mi_addr, mi_wdata);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               if (mi_addr !== e.addr || mi_wdata !== e.data) begin
                  bad++;
                  $display("[TB] FAIL write: got addr=%06h data=%02h required addr=%06h data=%02h",
                           mi_addr, mi_wdata, e.addr, e.data);
               end
            end
         end
         if (quiet_watch && (mi_we || mi_re || qpi_io_oe != 4'h0)) quiet_hits++;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic qpi_cycle(input logic [3:0] nib);
      qpi_io_i = nib;
      wait_clks(HALF);
      qpi_clk = 1'b1;
      wait_clks(HALF);
      qpi_clk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      qpi_cycle(b[7:4]);
      qpi_cycle(b[3:0]);
   endtask

   task automatic begin_txn(input logic [7:0] cmd, input logic [23:0] addr);
      qpi_cs_n = 1'b0;
      wait_clks(HALF);
      send_byte(cmd);
      send_byte(addr[23:16]);
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
   endtask

   task automatic end_txn();
      wait_clks(HALF);
      qpi_cs_n = 1'b1;
      wait_clks(4 * HALF);
   endtask

   // controller samples read data just before its rising edge
   task automatic read_nibbles(input int n, input string tag);
      logic [3:0] exp;
      logic [3:0] nib;
      logic [3:0] oe;
      for (int i = 0; i < n; i++) begin
         qpi_io_i = 4'h0;
         wait_clks(HALF);
         nib = qpi_io_o;
         oe  = qpi_io_oe;
         qpi_clk = 1'b1;
         wait_clks(HALF);
         qpi_clk = 1'b0;
         total++;
         if (nib_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s_nib%0d: got %h with no expectation queued", tag, i, nib);
         end else begin
            exp = nib_q.pop_front();
            if (nib !== exp || oe !== 4'hF) begin
               bad++;
               $display("[TB] FAIL %s_nib%0d: got io=%h oe=%h required io=%h oe=F", tag, i, nib, oe, exp);
            end
         end
      end
   endtask

   task automatic start_read(input logic [23:0] addr, input string tag);
      begin_txn(8'hEB, addr);
      total++;
      if (qpi_io_oe !== 4'h0) begin
         bad++;
         $display("[TB] FAIL %s_oe_before_data: got %h required 0", tag, qpi_io_oe);
      end
      for (int i = 0; i < DUMMY; i++) qpi_cycle(4'h0);
   endtask

   task automatic check_writes_drained(input string tag);
      total++;
      if (wr_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s_writes_missing: got %0d outstanding required 0", tag, wr_q.size());
         wr_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clks(5);
      total += 6;
      if (qpi_io_o !== 4'h0)    begin bad++; $display("[TB] FAIL reset_io_o: got %h required 0", qpi_io_o); end
      if (qpi_io_oe !== 4'h0)   begin bad++; $display("[TB] FAIL reset_io_oe: got %h required 0", qpi_io_oe); end
      if (mi_addr !== 24'h0)    begin bad++; $display("[TB] FAIL reset_mi_addr: got %h required 0", mi_addr); end
      if (mi_wdata !== 8'h0)    begin bad++; $display("[TB] FAIL reset_mi_wdata: got %h required 0", mi_wdata); end
      if (mi_we !== 1'b0)       begin bad++; $display("[TB] FAIL reset_mi_we: got %b required 0", mi_we); end
      if (mi_re !== 1'b0)       begin bad++; $display("[TB] FAIL reset_mi_re: got %b required 0", mi_re); end
      rst = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_idle();
      quiet_hits  = 0;
      quiet_watch = 1'b1;
      for (int i = 0; i < 100; i++) begin
         qpi_io_i = 4'($urandom_range(0, 15));
         if (i % 4 == 0) qpi_clk = ~qpi_clk;
         wait_clks(1);
      end
      quiet_watch = 1'b0;
      qpi_clk = 1'b0;
      wait_clks(HALF);
      total++;
      if (quiet_hits != 0) begin
         bad++;
         $display("[TB] FAIL idle_activity: got %0d active clks required 0", quiet_hits);
      end
   endtask

   task automatic test_write();
      wr_q.push_back('{addr: 24'h000010, data: 8'hA5});
      wr_q.push_back('{addr: 24'h000011, data: 8'h3C});
      begin_txn(8'h38, 24'h000010);
      send_byte(8'hA5);
      send_byte(8'h3C);
      end_txn();
      check_writes_drained("write");
   endtask

   task automatic test_read();
      nib_q.push_back(4'hA);
      nib_q.push_back(4'h5);
      nib_q.push_back(4'h3);
      nib_q.push_back(4'hC);
      start_read(24'h000010, "read");
      read_nibbles(4, "read");
      end_txn();
   endtask

   task automatic test_write_wrap();
      wr_q.push_back('{addr: 24'hFFFFFF, data: 8'h11});
      wr_q.push_back('{addr: 24'h000000, data: 8'h22});
      wr_q.push_back('{addr: 24'h000001, data: 8'h33});
      begin_txn(8'h38, 24'hFFFFFF);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      end_txn();
      check_writes_drained("wrap");
   endtask

   task automatic test_ignore();
      quiet_hits = 0;
      qpi_cs_n   = 1'b0;
      wait_clks(HALF);
      quiet_watch = 1'b1;
      send_byte(8'h9F);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
      wait_clks(HALF);
      quiet_watch = 1'b0;
      qpi_cs_n = 1'b1;
      wait_clks(4 * HALF);
      total++;
      if (quiet_hits != 0) begin
         bad++;
         $display("[TB] FAIL ignore_activity: got %0d active clks required 0", quiet_hits);
      end
      nib_q.push_back(4'hA);
      nib_q.push_back(4'h5);
      nib_q.push_back(4'h3);
      nib_q.push_back(4'hC);
      start_read(24'h000010, "after_ignore");
      read_nibbles(4, "after_ignore");
      end_txn();
   endtask

   task automatic test_abort();
      nib_q.push_back(4'hA);
      nib_q.push_back(4'h5);
      nib_q.push_back(4'h3);
      start_read(24'h000010, "abort_read");
      read_nibbles(3, "abort_read");
      qpi_cs_n = 1'b1;
      wait_clks(3);
      total++;
      if (qpi_io_oe !== 4'h0) begin
         bad++;
         $display("[TB] FAIL abort_read_oe: got %h required 0", qpi_io_oe);
      end
      wait_clks(4 * HALF);

      wr_q.push_back('{addr: 24'h000020, data: 8'h77});
      begin_txn(8'h38, 24'h000020);
      qpi_cycle(4'h7);
      qpi_cycle(4'h7);
      qpi_cycle(4'h1);
      qpi_cs_n = 1'b1;
      wait_clks(3);
      total++;
      if (qpi_io_oe !== 4'h0) begin
         bad++;
         $display("[TB] FAIL abort_write_oe: got %h required 0", qpi_io_oe);
      end
      wait_clks(4 * HALF);
      check_writes_drained("abort_write");

      nib_q.push_back(4'h7);
      nib_q.push_back(4'h7);
      start_read(24'h000020, "after_abort");
      read_nibbles(2, "after_abort");
      end_txn();
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      quiet_watch = 1'b0;
      quiet_hits  = 0;
      rst         = 1'b1;
      qpi_clk     = 1'b0;
      qpi_cs_n    = 1'b1;
      qpi_io_i    = 4'h0;
      test_reset();
      test_idle();
      test_write();
      test_read();
      test_write_wrap();
      test_ignore();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
